pll_reconfig_seq: RTL

Runtime reconfiguration sequencer for the system PLL, used to switch the core clocks between two video-region profiles (NTSC / PAL). It sits upstream of the PLL, driving the Avalon-MM management port of the PLL reconfiguration controller that feeds the PLL's 64-bit reconfiguration bus. It programs M, fractional K and C0–C3, triggers the reconfiguration, and holds the core in reset until the PLL is stably locked again.

---
 rtl/pll_reconfig_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pll_reconfig_seq.sv
// PLL runtime reconfiguration sequencer. It programs M, K and C0-C3 for one of two profiles
// through the reconfig controller's Avalon-MM management port, starts the reconfiguration,
// and holds the core in reset until the PLL has stayed locked for LOCK_HOLD cycles.
`timescale 1ns/1ps
module pll_reconfig_seq #(
  parameter logic [191:0] P0_WORDS     = {32'h000C_3838, 32'h0008_3838, 32'h0004_0E0E,
                                          32'h0002_0403, 32'd425907062,  32'h0000_0404},
  parameter logic [191:0] P1_WORDS     = P0_WORDS,
  parameter int unsigned  LOCK_HOLD    = 1024,
  parameter int unsigned  LOCK_TIMEOUT = 1 << 20
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        profile_sel,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  output logic        busy,
  output logic        active_profile,
  output logic        core_reset_n,
  output logic        lock_err
);

  localparam int unsigned HW = $clog2(LOCK_HOLD + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LOCK_HOLD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StWrMode, StWrWord, StWrStart, StWaitDone, StWaitLock
  } state_e;

  state_e        state_q, state_d;
  logic          target_q, target_d;
  logic [2:0]    idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          write_q, write_d;
  logic [5:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          active_q, active_d;
  logic          core_rst_n_q, core_rst_n_d;
  logic          lock_err_q, lock_err_d;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic [191:0]  prof;

  assign locked_s = sync_q[1];
  assign prof     = target_q ? P1_WORDS : P0_WORDS;

  // Register address for each profile word: M, K, then the four counters share one address.
  function automatic logic [5:0] word_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    word_addr = 6'd4;
      3'd1:    word_addr = 6'd7;
      default: word_addr = 6'd5;
    endcase
  endfunction

  function automatic logic [31:0] word_data(input logic [191:0] p, input logic [2:0] idx);
    word_data = p[{idx, 5'd0} +: 32];
  endfunction

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], pll_locked};
  end

  // State and registered outputs.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      target_q     <= 1'b0;
      idx_q        <= 3'd0;
      hold_q       <= '0;
      tmo_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= 6'd0;
      data_q       <= 32'd0;
      active_q     <= 1'b0;
      core_rst_n_q <= 1'b0;
      lock_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      tmo_q        <= tmo_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      active_q     <= active_d;
      core_rst_n_q <= core_rst_n_d;
      lock_err_q   <= lock_err_d;
    end
  end

  // Next-state logic. In each write state a cycle with write_q low is the mandatory gap;
  // the gap cycle launches the next write (or the next state) so every write is followed
  // by exactly one idle cycle.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    tmo_d      = tmo_q;
    write_d    = write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    active_d   = active_q;
    lock_err_d = lock_err_q;

    unique case (state_q)
      StIdle: begin
        if (profile_sel != active_q) begin
          target_d = profile_sel;
          state_d  = StWrMode;
          write_d  = 1'b1;
          addr_d   = 6'd0;
          data_d   = 32'd0;
        end
      end
      StWrMode: begin
        if (write_q) begin
          if (!mgmt_waitrequest) write_d = 1'b0;
        end else begin
          state_d = StWrWord;
          idx_d   = 3'd0;
          write_d = 1'b1;
          addr_d  = word_addr(3'd0);
          data_d  = word_data(prof, 3'd0);
        end
      end
      StWrWord: begin
        if (write_q) begin
          if (!mgmt_waitrequest) write_d = 1'b0;
        end else if (idx_q == 3'd5) begin
          state_d = StWrStart;
          write_d = 1'b1;
          addr_d  = 6'd2;
          data_d  = 32'd0;
        end else begin
          idx_d   = idx_q + 3'd1;
          write_d = 1'b1;
          addr_d  = word_addr(idx_q + 3'd1);
          data_d  = word_data(prof, idx_q + 3'd1);
        end
      end
      StWrStart: begin
        if (write_q) begin
          if (!mgmt_waitrequest) write_d = 1'b0;
        end else begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        // Controller drops waitrequest once the reconfiguration has been applied.
        if (!mgmt_waitrequest) begin
          hold_d  = '0;
          tmo_d   = '0;
          state_d = StWaitLock;
        end
      end
      StWaitLock: begin
        hold_d = locked_s ? hold_q + 1'b1 : '0;
        tmo_d  = tmo_q + 1'b1;
        if (locked_s && hold_q == HOLD_LAST) begin
          active_d = target_q;
          state_d  = StIdle;
        end else if (tmo_q == TMO_LAST) begin
          // Give up but still record the profile: the PLL registers were rewritten.
          lock_err_d = 1'b1;
          active_d   = target_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    core_rst_n_d = (state_d == StIdle) && locked_s;
  end

  assign mgmt_address   = addr_q;
  assign mgmt_write     = write_q;
  assign mgmt_writedata = data_q;
  assign busy           = (state_q != StIdle);
  assign active_profile = active_q;
  assign core_reset_n   = core_rst_n_q;
  assign lock_err       = lock_err_q;

endmodule
